// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and default decode constants for the Z80 bus responder/monitor
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } resp_state_t;

    typedef enum logic [2:0] {
        MEM_RD,
        MEM_WR,
        IO_RD,
        IO_WR,
        INTACK
    } cyc_kind_t;

    localparam logic [15:0] DEF_MEM_MASK  = 16'hC000;
    localparam logic [15:0] DEF_MEM_MATCH = 16'h0000;
    localparam logic [7:0]  DEF_IO_MASK   = 8'hF0;
    localparam logic [7:0]  DEF_IO_MATCH  = 8'h10;

    // I/O and interrupt-acknowledge cycles are framed by nIORQ, memory cycles by nMREQ
    function automatic logic kind_uses_iorq(input cyc_kind_t kind);
        return (kind == IO_RD) || (kind == IO_WR) || (kind == INTACK);
    endfunction

    function automatic logic kind_is_write(input cyc_kind_t kind);
        return (kind == MEM_WR) || (kind == IO_WR);
    endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// rtl/z80_cycle_decode.sv - combinational start/kind/hit decode of Z80 pin state
module z80_cycle_decode
    import bus_pkg::*;
#(
    parameter logic [15:0] MEM_MASK  = DEF_MEM_MASK,
    parameter logic [15:0] MEM_MATCH = DEF_MEM_MATCH,
    parameter logic [7:0]  IO_MASK   = DEF_IO_MASK,
    parameter logic [7:0]  IO_MATCH  = DEF_IO_MATCH
) (
    input  logic [15:0] addr,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic        start,
    output logic        intack,
    output cyc_kind_t   kind,
    output logic [15:0] bus_addr
);

    logic one_strobe;
    logic mem_hit;
    logic io_hit;
    logic mem_cyc;
    logic io_cyc;

    always_comb begin
        one_strobe = rd_n ^ wr_n;
        mem_hit    = (addr & MEM_MASK) == MEM_MATCH;
        io_hit     = (addr[7:0] & IO_MASK) == IO_MATCH;
        // each cycle type requires the other request strobe idle, so overlapping strobes never start
        mem_cyc    = !mreq_n && iorq_n && rfsh_n && one_strobe && mem_hit;
        io_cyc     = !iorq_n && mreq_n && m1_n && one_strobe && io_hit;
        intack     = !iorq_n && mreq_n && !m1_n;
        start      = mem_cyc || io_cyc;

        if (io_cyc) begin
            kind = rd_n ? IO_WR : IO_RD;
        end else if (intack) begin
            kind = INTACK;
        end else begin
            kind = rd_n ? MEM_WR : MEM_RD;
        end

        bus_addr = io_cyc ? {8'h00, addr[7:0]} : addr;
    end

endmodule

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - answers Z80 bus cycles via a req/ack store; RESP_INTACK_EN adds interrupt-acknowledge vectoring
module z80_bus_responder
    import bus_pkg::*;
#(
    parameter logic [15:0] MEM_MASK  = DEF_MEM_MASK,
    parameter logic [15:0] MEM_MATCH = DEF_MEM_MATCH,
    parameter logic [7:0]  IO_MASK   = DEF_IO_MASK,
    parameter logic [7:0]  IO_MATCH  = DEF_IO_MATCH,
    parameter int unsigned MIN_WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    inout  wire  [7:0]  D,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    output logic        nWAIT,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  int_vector
);

`ifdef RESP_INTACK_EN
    localparam logic INTACK_EN = 1'b1;
`else
    localparam logic INTACK_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_INIT = 4'(MIN_WAIT);

    resp_state_t state;
    resp_state_t state_nxt;
    cyc_kind_t   kind_q;
    cyc_kind_t   dec_kind;
    logic        dec_start;
    logic        dec_intack;
    logic [15:0] dec_addr;
    logic        dec_we;
    logic        dec_io;

    logic        start_ok;
    logic        intack_ok;
    logic        strobe_hi;
    logic        ack_now;
    logic        wait_done;

    logic        req_q;
    logic        ack_seen_q;
    logic        abort_q;
    logic [3:0]  cnt_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        we_q;
    logic        io_q;

    logic        d_oe;
    logic [7:0]  d_out;

    z80_cycle_decode #(
        .MEM_MASK  (MEM_MASK),
        .MEM_MATCH (MEM_MATCH),
        .IO_MASK   (IO_MASK),
        .IO_MATCH  (IO_MATCH)
    ) u_decode (
        .addr     (A),
        .m1_n     (nM1),
        .mreq_n   (nMREQ),
        .iorq_n   (nIORQ),
        .rd_n     (nRD),
        .wr_n     (nWR),
        .rfsh_n   (nRFSH),
        .start    (dec_start),
        .intack   (dec_intack),
        .kind     (dec_kind),
        .bus_addr (dec_addr)
    );

    // Starts are masked during reset so a strobe still low from an abandoned cycle cannot re-launch it
    always_comb begin
        dec_we    = kind_is_write(dec_kind);
        dec_io    = (dec_kind == IO_RD) || (dec_kind == IO_WR);
        start_ok  = (state == IDLE) && !reset && dec_start;
        intack_ok = INTACK_EN && (state == IDLE) && !reset && dec_intack;
        strobe_hi = kind_uses_iorq(kind_q) ? nIORQ : nMREQ;
        ack_now   = req_q && mem_ack;
        wait_done = ack_seen_q && (cnt_q == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = REQ;
                end else if (intack_ok) begin
                    state_nxt = DATA;
                end
            end
            REQ: begin
                // an aborted cycle waits out the store's ack but never enters DATA
                if ((abort_q || strobe_hi) && (ack_seen_q || mem_ack)) begin
                    state_nxt = IDLE;
                end else if (!abort_q && !strobe_hi && wait_done) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (strobe_hi) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        nWAIT     = 1'b1;
        mem_req   = req_q || start_ok;
        mem_we    = start_ok ? dec_we : we_q;
        mem_io    = start_ok ? dec_io : io_q;
        mem_addr  = start_ok ? dec_addr : addr_q;
        mem_wdata = (start_ok && dec_we) ? D : wdata_q;
        d_oe      = 1'b0;
        d_out     = rdata_q;

        unique case (state)
            IDLE: begin
                // the Z80 samples nWAIT in T2, which is the start cycle itself
                if (start_ok) begin
                    nWAIT = 1'b0;
                end
                d_oe  = intack_ok;
                d_out = int_vector;
            end
            REQ: begin
                if (!abort_q && !strobe_hi && !wait_done) begin
                    nWAIT = 1'b0;
                end
            end
            DATA: begin
                d_oe = (kind_q == INTACK) ? !nIORQ : (!we_q && !nRD);
            end
            default: ;
        endcase
    end

    assign D = d_oe ? d_out : 8'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q     <= MEM_RD;
            req_q      <= 1'b0;
            ack_seen_q <= 1'b0;
            abort_q    <= 1'b0;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        kind_q     <= dec_kind;
                        addr_q     <= dec_addr;
                        we_q       <= dec_we;
                        io_q       <= dec_io;
                        req_q      <= !mem_ack;
                        ack_seen_q <= mem_ack;
                        abort_q    <= 1'b0;
                        cnt_q      <= WAIT_INIT;
                        if (dec_we) begin
                            wdata_q <= D;
                        end else if (mem_ack) begin
                            rdata_q <= mem_rdata;
                        end
                    end else if (intack_ok) begin
                        kind_q  <= INTACK;
                        rdata_q <= int_vector;
                    end
                end
                REQ: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                    if (ack_now) begin
                        req_q      <= 1'b0;
                        ack_seen_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end
                    if (strobe_hi) begin
                        abort_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb/tb_z80_bus_responder.sv - table-driven bench for z80_bus_responder (MIN_WAIT 0 and 3 instances)
module tb_z80_bus_responder;

    // the data buses are pulled up, so an undriven bus reads all ones
    localparam logic [7:0] ZV = 8'hFF;
`ifdef RESP_INTACK_EN
    localparam logic [7:0] IV_EXP = 8'hFE;
`else
    localparam logic [7:0] IV_EXP = ZV;
`endif

    // pin groups {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH}
    localparam logic [5:0] P_IDLE  = 6'b111111;
    localparam logic [5:0] P_MRD   = 6'b101011;
    localparam logic [5:0] P_MWR   = 6'b101101;
    localparam logic [5:0] P_MRDHI = 6'b101111;
    localparam logic [5:0] P_IORD  = 6'b110011;
    localparam logic [5:0] P_RFSH  = 6'b101010;
    localparam logic [5:0] P_RDWR  = 6'b101001;
    localparam logic [5:0] P_BOTHQ = 6'b100011;
    localparam logic [5:0] P_INTA  = 6'b010111;

    typedef struct {
        logic        rst;
        logic [5:0]  p;
        logic [15:0] a;
        logic        ack;
        logic [7:0]  rdata;
        logic [7:0]  iv;
        logic        e_nw;
        logic        e_rq;
        logic [7:0]  e_d;
        logic        chk;
        logic [15:0] e_addr;
        logic        e_we;
        logic        e_io;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic        n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  int_vector;
    logic [7:0]  tb_d;
    logic        tb_oe;
    wire  [7:0]  d0;
    wire  [7:0]  d3;

    logic        n_wait0, mem_req0, mem_we0, mem_io0;
    logic [15:0] mem_addr0;
    logic [7:0]  mem_wdata0;
    logic        n_wait3, mem_req3, mem_we3, mem_io3;
    logic [15:0] mem_addr3;
    logic [7:0]  mem_wdata3;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign d0 = tb_oe ? tb_d : 8'bz;
    assign d3 = tb_oe ? tb_d : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (d0[i]);
        pullup (d3[i]);
    end

    z80_bus_responder #(.MIN_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .A(a), .D(d0), .nM1(n_m1), .nMREQ(n_mreq),
        .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .nWAIT(n_wait0),
        .mem_req(mem_req0), .mem_we(mem_we0), .mem_io(mem_io0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .int_vector(int_vector)
    );

    z80_bus_responder #(.MIN_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .A(a), .D(d3), .nM1(n_m1), .nMREQ(n_mreq),
        .nIORQ(n_iorq), .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .nWAIT(n_wait3),
        .mem_req(mem_req3), .mem_we(mem_we3), .mem_io(mem_io3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .int_vector(int_vector)
    );

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [5:0] p, input logic [15:0] a_v,
                                input logic ack, input logic [7:0] rdata, input logic [7:0] iv,
                                input logic e_nw, input logic e_rq, input logic [7:0] e_d,
                                input logic chk_en, input logic [15:0] e_addr,
                                input logic e_we, input logic e_io);
        vec_t v;
        v.rst = rst; v.p = p; v.a = a_v; v.ack = ack; v.rdata = rdata; v.iv = iv;
        v.e_nw = e_nw; v.e_rq = e_rq; v.e_d = e_d; v.chk = chk_en;
        v.e_addr = e_addr; v.e_we = e_we; v.e_io = e_io;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        logic done;

        reset = 1'b1; a = 16'h0000; {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh} = P_IDLE;
        mem_ack = 1'b0; mem_rdata = 8'h00; int_vector = 8'hFE; tb_d = 8'h00; tb_oe = 1'b0;

        // memory read, ack in the start cycle
        tbl.push_back(mk(0, P_MRD,   16'h1234, 1, 8'h5A, 8'hFE, 0, 1, ZV,    1, 16'h1234, 0, 0));
        tbl.push_back(mk(0, P_MRD,   16'h1234, 0, 8'h00, 8'hFE, 1, 0, ZV,    1, 16'h1234, 0, 0));
        tbl.push_back(mk(0, P_MRD,   16'h1234, 0, 8'h00, 8'hFE, 1, 0, 8'h5A, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_MRDHI, 16'h1234, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h1234, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h1234, 0, 8'h00, 8'hFE, 1, 0, ZV,    1, 16'h1234, 0, 0));
        // I/O read, ack five clocks after start
        tbl.push_back(mk(0, P_IORD,  16'hFF12, 0, 8'h00, 8'hFE, 0, 1, ZV,    1, 16'h0012, 0, 1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, P_IORD, 16'hFF12, 0, 8'h00, 8'hFE, 0, 1, ZV, 1, 16'h0012, 0, 1));
        tbl.push_back(mk(0, P_IORD,  16'hFF12, 1, 8'hC3, 8'hFE, 0, 1, ZV,    1, 16'h0012, 0, 1));
        tbl.push_back(mk(0, P_IORD,  16'hFF12, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IORD,  16'hFF12, 0, 8'h00, 8'hFE, 1, 0, 8'hC3, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'hFF12, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'hFF12, 0, 8'h00, 8'hFE, 1, 0, ZV,    1, 16'h0012, 0, 1));
        // miss, refresh, both strobes, both requests, I/O miss
        tbl.push_back(mk(0, P_MRD,   16'h8000, 1, 8'h11, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h8000, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_RFSH,  16'h0010, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_RDWR,  16'h0010, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_BOTHQ, 16'h0010, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IORD,  16'h0020, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0000, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        // abort: strobe rises while the store has not answered
        tbl.push_back(mk(0, P_MRD,   16'h0200, 0, 8'h00, 8'hFE, 0, 1, ZV,    1, 16'h0200, 0, 0));
        tbl.push_back(mk(0, P_MRD,   16'h0200, 0, 8'h00, 8'hFE, 0, 1, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0200, 0, 8'h00, 8'hFE, 1, 1, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0200, 0, 8'h00, 8'hFE, 1, 1, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0200, 1, 8'h77, 8'hFE, 1, 1, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0200, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        // interrupt acknowledge; vector changes after the start cycle
        tbl.push_back(mk(0, P_INTA,  16'h0000, 0, 8'h00, 8'hFE, 1, 0, IV_EXP, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_INTA,  16'h0000, 0, 8'h00, 8'h00, 1, 0, IV_EXP, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0000, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0000, 0, 8'h00, 8'hFE, 1, 0, ZV,    0, 16'h0000, 0, 0));
        // reset in the middle of a pending request
        tbl.push_back(mk(0, P_MRD,   16'h0300, 0, 8'h00, 8'hFE, 0, 1, ZV,    1, 16'h0300, 0, 0));
        tbl.push_back(mk(0, P_MRD,   16'h0300, 0, 8'h00, 8'hFE, 0, 1, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, P_MRD,   16'h0300, 0, 8'h00, 8'hFE, 0, 1, ZV,    0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, P_MRD,   16'h0300, 0, 8'h00, 8'hFE, 1, 0, ZV,    1, 16'h0000, 0, 0));
        tbl.push_back(mk(0, P_IDLE,  16'h0300, 0, 8'h00, 8'hFE, 1, 0, ZV,    1, 16'h0000, 0, 0));

        repeat (3) @(negedge clk);
        #2;
        chk("rst_nwait", 0, 16'(n_wait0), 16'd1);
        chk("rst_req", 0, 16'(mem_req0), 16'd0);
        chk("rst_addr", 0, mem_addr0, 16'h0000);
        chk("rst_we_io", 0, {14'd0, mem_we0, mem_io0}, 16'd0);
        chk("rst_wdata", 0, 16'(mem_wdata0), 16'd0);
        chk("rst_d", 0, 16'(d0), 16'(ZV));
        chk("rst_nwait3", 0, 16'(n_wait3), 16'd1);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh} = tbl[i].p;
            a = tbl[i].a;
            mem_ack = tbl[i].ack;
            mem_rdata = tbl[i].rdata;
            int_vector = tbl[i].iv;
            #2;
            chk("nwait", i, 16'(n_wait0), 16'(tbl[i].e_nw));
            chk("mem_req", i, 16'(mem_req0), 16'(tbl[i].e_rq));
            chk("d_pins", i, 16'(d0), 16'(tbl[i].e_d));
            if (tbl[i].chk) begin
                chk("mem_addr", i, mem_addr0, tbl[i].e_addr);
                chk("mem_we", i, 16'(mem_we0), 16'(tbl[i].e_we));
                chk("mem_io", i, 16'(mem_io0), 16'(tbl[i].e_io));
            end
        end

        // memory write on the MIN_WAIT=3 instance, ack one clock after start
        @(negedge clk);
        reset = 1'b0; int_vector = 8'hFE;
        {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh} = P_MWR;
        a = 16'h0100; tb_d = 8'hA5; tb_oe = 1'b1;
        low = 0; done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            mem_ack = (c == 1);
            #2;
            if (c == 0) begin
                chk("wr_start_we", 0, 16'(mem_we3), 16'd1);
                chk("wr_start_wdata", 0, 16'(mem_wdata3), 16'h00A5);
                chk("wr_start_req", 0, 16'(mem_req3), 16'd1);
            end
            if (n_wait3) begin
                done = 1'b1;
                break;
            end
            low++;
        end
        chk("wr_released", 0, 16'(done), 16'd1);
        chk("wr_wait_low", 0, 16'(low), 16'd4);
        chk("wr_req_done", 0, 16'(mem_req3), 16'd0);
        chk("wr_we", 0, 16'(mem_we3), 16'd1);
        chk("wr_addr", 0, mem_addr3, 16'h0100);
        @(negedge clk);
        mem_ack = 1'b0; tb_oe = 1'b0;
        {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh} = P_IDLE;
        @(negedge clk);
        #2;
        chk("wr_wdata_hold", 0, 16'(mem_wdata3), 16'h00A5);
        chk("wr_idle_nwait", 0, 16'(n_wait3), 16'd1);

        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("rst3_wdata", 0, 16'(mem_wdata3), 16'd0);
        chk("rst3_we", 0, 16'(mem_we3), 16'd0);
        chk("rst3_addr", 0, mem_addr3, 16'h0000);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- External-side responder for the CPU pin interface: the counterpart that answers bus cycles driven by the address/data pin blocks.
- Watches the address pins, control strobes and the bidirectional data pins.
- Decodes memory or I/O read/write cycles inside a configurable window and forwards each one to a backing store through a req/ack handshake.
- Holds nWAIT low until the store answers, drives the data pins on reads and captures them on writes.
- Used as the memory/I/O model in bus-level benches and as the glue to on-chip RAM/peripherals.

Parameters:
- MEM_MASK, 16'hC000, address bits compared for memory-cycle decode
- MEM_MATCH, 16'h0000, required value of (A & MEM_MASK) for a memory hit
- IO_MASK, 8'hF0, A[7:0] bits compared for I/O-cycle decode
- IO_MATCH, 8'h10, required value of (A[7:0] & IO_MASK) for an I/O hit
- MIN_WAIT, 0, minimum clocks nWAIT stays low per cycle, range 0..15; 0 means no wait when ack arrives in the request cycle

Ports:
- clk  in  1  system clock, same clock as the CPU core
- reset  in  1  synchronous, active-high reset
- A  in  16  address pins
- D  inout  8  data pins; tri-stated unless driving a read
- nM1  in  1  opcode-fetch strobe, active low
- nMREQ  in  1  memory request, active low
- nIORQ  in  1  I/O request, active low
- nRD  in  1  read strobe, active low
- nWR  in  1  write strobe, active low
- nRFSH  in  1  refresh strobe, active low
- nWAIT  out  1  wait request to CPU, active low
- mem_req  out  1  backing-store request, level, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_io  out  1  1 = I/O space, 0 = memory space; valid while mem_req
- mem_addr  out  16  latched address; I/O cycles place A[7:0] in bits [7:0] and zero the upper byte
- mem_wdata  out  8  latched write data
- mem_rdata  in  8  read data; valid when mem_ack is high
- mem_ack  in  1  one-clock acknowledge from the backing store
- int_vector  in  8  interrupt-acknowledge vector; used only with the optional feature

Behaviour:
- Reset values: nWAIT=1, mem_req=0, mem_we=0, mem_io=0, mem_addr=0, mem_wdata=0, D=Z, state=IDLE, wait counter=0.
- Reset asserted mid-cycle forces these values on the next edge. Any pending store request is abandoned; the store must tolerate a dropped request.
- All pin inputs are synchronous to clk. There is no synchronizer.
- Start condition, evaluated in IDLE:
  - memory: nMREQ=0, nRFSH=1, exactly one of nRD/nWR low, address hit
  - I/O: nIORQ=0, nM1=1, exactly one of nRD/nWR low, address hit
- Any of the following leaves the responder in IDLE with D=Z and nWAIT=1: refresh cycles, a miss, nRD and nWR both low, nMREQ and nIORQ both low.
- States:
  - IDLE: on start, latch A, D (writes only), type and direction. Assert mem_req and drive nWAIT=0 combinationally in the start cycle (Z80 samples nWAIT in T2). Load counter=MIN_WAIT. Go to REQ.
  - REQ: mem_req held. On mem_ack, deassert mem_req and latch mem_rdata for reads. When mem_ack has been seen AND counter==0, release nWAIT (nWAIT=1) and go to DATA. Counter decrements each clock, saturating at 0.
  - DATA: reads drive D with the latched data while nRD=0. Writes hold mem_wdata. Go to IDLE when the active strobe (nMREQ or nIORQ) returns high. D goes Z in the same clock nRD goes high.
- Minimum latency: start to nWAIT=1 is 1 clock when ack arrives in the start cycle and MIN_WAIT=0. Otherwise it is max(ack clock, MIN_WAIT) + 1.
- Abort: if the strobe rises while in REQ, keep mem_req until mem_ack, never drive D, then return to IDLE.
- A new cycle cannot start until IDLE is re-entered. Back-to-back cycles need at least one clock of strobe high, which the Z80 protocol guarantees.

Optional Feature:
- Macro: RESP_INTACK_EN.
- Defined: nM1=0 with nIORQ=0 is an interrupt-acknowledge cycle. No store request is issued. nWAIT stays 1. D is driven with int_vector, sampled in the start cycle, until nIORQ rises.
- Not defined: this combination is ignored (D=Z, nWAIT=1), and the int_vector port is still present but unused.

Decomposition:
- Shared package bus_pkg:
  - enum resp_state_t {IDLE, REQ, DATA}
  - typedef cyc_kind_t {MEM_RD, MEM_WR, IO_RD, IO_WR, INTACK}
  - default mask/match constants
- One sub-module, z80_cycle_decode: purely combinational start/kind/hit decode from pins and parameters. It is reused by a future bus monitor.
- The state machine, wait counter and data latches stay in the top module.

Test Plan:
- Memory read, MIN_WAIT=0: A=16'h1234, nMREQ=0, nRD=0, ack in the same clock with rdata=8'h5A. Expect mem_addr=16'h1234, mem_we=0, nWAIT low 1 clock, D=8'h5A until nRD rises, then D=Z.
- Memory write, MIN_WAIT=3: A=16'h0100, D=8'hA5, nWR=0, ack after 1 clock. Expect mem_we=1, mem_wdata=8'hA5, nWAIT low exactly 4 clocks.
- I/O read, slow store: A=16'hFF12, nIORQ=0, nRD=0, ack after 5 clocks. Expect mem_io=1, mem_addr=16'h0012, nWAIT low 6 clocks, D driven afterwards.
- Miss and refresh: A=16'h8000 read, then a refresh cycle with nMREQ=0, nRFSH=0. Expect mem_req never asserted, D=Z, nWAIT=1.
- Abort and reset: strobe rises in REQ. Expect mem_req held until ack, no D drive. Then reset pulsed mid-REQ of a new cycle; expect all outputs at reset values next clock.
- With RESP_INTACK_EN, int_vector=8'hFE, nM1=0, nIORQ=0: expect D=8'hFE, mem_req=0, nWAIT=1. Without the macro: D=Z.
